seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 109 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a per-digit value register file.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_EN.
module seg_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int DIV  = 1000,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [3:0]      wr_data,
  input  logic [NDIG-1:0] blank_mask,
  output logic [7:0]      o_seg,
  output logic [NDIG-1:0] o_an
);

  localparam int CW = $clog2(DIV);
  localparam int XW = $clog2(NDIG);

  logic [CW-1:0]   r_cnt;
  logic [XW-1:0]   r_idx;
  logic [3:0]      r_digit [NDIG];
  logic [7:0]      r_seg;
  logic [NDIG-1:0] r_an;

  logic            w_slotEnd;
  logic            w_wrHit;
  logic            w_lit;
  logic [3:0]      w_value;
  logic [NDIG-1:0] w_lzDark;

  function automatic logic [7:0] hexPattern(input logic [3:0] v);
    logic [7:0] p;
    case (v)
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  assign w_slotEnd = (r_cnt == CW'(DIV - 1));
  assign w_wrHit   = wr_en && (32'(wr_idx) < NDIG);
  assign w_value   = r_digit[r_idx];

`ifdef SEG_SCAN_LZ_EN
  // A digit goes dark when it and every more significant digit hold zero; digit 0 always shows.
  always_comb begin
    logic upperZero;
    w_lzDark  = '0;
    upperZero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      upperZero   = upperZero && (r_digit[i] == 4'h0);
      w_lzDark[i] = upperZero;
    end
  end
`else
  assign w_lzDark = '0;
`endif

  // cnt == 0 is the dead cycle that separates adjacent digits.
  assign w_lit = en && !blank_mask[r_idx] && !w_lzDark[r_idx] && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      for (int i = 0; i < NDIG; i++) begin
        r_digit[i] <= 4'h0;
      end
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else begin
      r_cnt <= w_slotEnd ? '0 : r_cnt + CW'(1);
      if (w_slotEnd) begin
        r_idx <= (r_idx == XW'(NDIG - 1)) ? '0 : r_idx + XW'(1);
      end
      if (w_wrHit) begin
        r_digit[XW'(wr_idx)] <= wr_data;
      end
      if (w_lit) begin
        r_seg <= ~hexPattern(w_value);
        r_an  <= ~(NDIG'(1) << r_idx);
      end else begin
        r_seg <= 8'hFF;
        r_an  <= '1;
      end
    end
  end

  assign o_seg = r_seg;
  assign o_an  = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a time-based reference model checked every cycle,
// plus directed literal checks of scan order, write latency, blanking and reset.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int IW   = 3;
  localparam int SCAN = NDIG * DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            wr_en = 1'b0;
  logic [IW-1:0]   wr_idx = '0;
  logic [3:0]      wr_data = '0;
  logic [NDIG-1:0] blank_mask = '0;
  logic [7:0]      o_seg;
  logic [NDIG-1:0] o_an;

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

`ifdef SEG_SCAN_LZ_EN
  logic [3:0] scanSeq [SCAN] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                                 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`else
  logic [3:0] scanSeq [SCAN] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
`endif

  // Model state: number of edges since reset released, and the digit values.
  int              mT = 0;
  logic [3:0]      mReg [NDIG];
  logic [7:0]      expSeg = 8'hFF;
  logic [NDIG-1:0] expAn = '1;
  bit              expValid = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .o_seg      (o_seg),
    .o_an       (o_an)
  );

  function automatic bit lzDark(input int d);
`ifdef SEG_SCAN_LZ_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < NDIG; j++) begin
      if (mReg[j] != 4'h0) return 1'b0;
    end
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  // Reference model: slot position follows directly from elapsed time since reset.
  always @(posedge clk) begin
    int  cnt;
    int  idx;
    bit  lit;
    if (rst) begin
      mT = 0;
      for (int i = 0; i < NDIG; i++) mReg[i] = 4'h0;
      expSeg = 8'hFF;
      expAn  = '1;
    end else begin
      cnt = mT % DIV;
      idx = (mT / DIV) % NDIG;
      lit = (cnt != 0) && en && !blank_mask[idx] && !lzDark(idx);
      expSeg = lit ? ~pat[mReg[idx]] : 8'hFF;
      expAn  = lit ? ~(4'b0001 << idx) : 4'hF;
      mT++;
      if (wr_en && (int'(wr_idx) < NDIG)) mReg[int'(wr_idx)] = wr_data;
    end
    expValid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("model o_seg", {24'd0, o_seg}, {24'd0, expSeg});
      checkOutput("model o_an", {28'd0, o_an}, {28'd0, expAn});
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic we,
                               input logic [IW-1:0] wi, input logic [3:0] wd,
                               input logic [NDIG-1:0] bm);
    rst        = r;
    en         = e;
    wr_en      = we;
    wr_idx     = wi;
    wr_data    = wd;
    blank_mask = bm;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic waitPhase(input int target);
    int n = 0;
    while ((mT % SCAN) != target && n < 2 * SCAN) begin
      idle(1);
      n++;
    end
    checkOutput("phase reached", mT % SCAN, target);
  endtask

  // Called while rst is high; releases it and checks one complete scan of zeroed digits.
  task automatic checkScanFromReset();
    int badSeg = 0;
    for (int i = 0; i < SCAN; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'h0, '0);
      checkOutput("scan anode", {28'd0, o_an}, {28'd0, scanSeq[i]});
      if (o_an != 4'hF && o_seg != 8'h03) badSeg++;
      if (o_an == 4'hF && o_seg != 8'hFF) badSeg++;
    end
    checkOutput("scan zero digits", badSeg, 0);
  endtask

  initial begin
    int cnt;
    int cntE;
    int cntD;
    logic [NDIG-1:0] bm;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0, 4'h0, '0);
    checkOutput("reset o_seg", {24'd0, o_seg}, 32'hFF);
    checkOutput("reset o_an", {28'd0, o_an}, 32'hF);
    checkScanFromReset();

    // Write digit 2 at cnt==2 of its slot; new value must show on the next output.
    waitPhase(2 * DIV + 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 4'hA, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'h0, '0);
    checkOutput("write latency seg", {24'd0, o_seg}, 32'h11);
    checkOutput("write latency an", {28'd0, o_an}, 32'hB);
    checkOutput("model pin 0xA", {24'd0, expSeg}, 32'h11);

    cnt = 0;
    for (int i = 0; i < SCAN; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'h0, 4'b0010);
      if (o_an == 4'hD) cnt++;
    end
    checkOutput("blank slot1", cnt, 0);

    cnt = 0;
    for (int i = 0; i < SCAN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 4'h0, '0);
      if (o_an != 4'hF || o_seg != 8'hFF) cnt++;
    end
    checkOutput("enable off dark", cnt, 0);
    idle(DIV);

    applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, 4'h9, '0);
    cnt = 0;
    for (int i = 0; i < SCAN; i++) begin
      idle(1);
      if (o_seg == 8'h09) cnt++;
    end
    checkOutput("out of range write", cnt, 0);

`ifdef SEG_SCAN_LZ_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 4'h0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 4'h7, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 4'h0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 4'h0, '0);
    cnt = 0; cntE = 0; cntD = 0;
    for (int i = 0; i < SCAN; i++) begin
      idle(1);
      if (o_an == 4'hE && o_seg == 8'h03) cntE++;
      if (o_an == 4'hD && o_seg == 8'h1F) cntD++;
      if (o_an == 4'hB || o_an == 4'h7) cnt++;
    end
    checkOutput("lz digit0 lit", cntE, DIV - 1);
    checkOutput("lz digit1 lit", cntD, DIV - 1);
    checkOutput("lz upper dark", cnt, 0);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 4'h7, '0);
    cntD = 0;
    for (int i = 0; i < SCAN; i++) begin
      idle(1);
      if (o_an == 4'hD && o_seg == 8'h1F) cntD++;
    end
    checkOutput("digit1 shows 7", cntD, DIV - 1);
`endif

    // Reset at cnt==2 of slot 3 must blank immediately and clear every digit.
    waitPhase(3 * DIV + 2);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'h0, '0);
    checkOutput("midscan reset seg", {24'd0, o_seg}, 32'hFF);
    checkOutput("midscan reset an", {28'd0, o_an}, 32'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'h0, '0);
    checkScanFromReset();

    for (int i = 0; i < 600; i++) begin
      bm = ($urandom_range(0, 3) == 0) ? NDIG'($urandom) : '0;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)),
                    4'($urandom), bm);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 4'h0, '0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
